// File: rtl/set_assoc_cache.sv
// N-way set-associative, write-back / write-allocate byte cache with true-LRU
// replacement, a line-wide req/ack backing-memory port and hit/miss counters.
module set_assoc_cache #(
  parameter int SIZE       = 1024,
  parameter int LINE_BYTES = 4,
  parameter int WAYS       = 2,
  parameter int ADDR_WIDTH = 16,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req,
  input  logic                    we,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [7:0]              wdata,
  output logic                    ready,
  output logic                    done,
  output logic [7:0]              rdata,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [LINE_BYTES*8-1:0] mem_wdata,
  input  logic [LINE_BYTES*8-1:0] mem_rdata,
  input  logic                    mem_ack,
  output logic [CNT_WIDTH-1:0]    hit_count,
  output logic [CNT_WIDTH-1:0]    miss_count
);
  localparam int LINE_W = LINE_BYTES * 8;
  localparam int SETS   = SIZE / (LINE_BYTES * WAYS);
  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_WIDTH - IDX_W - OFF_W;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {IDLE, LOOKUP, WRITEBACK, REFILL} state_t;

  state_t                r_state, w_next;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_wdata;
  logic                  r_first;
  logic [WAY_W-1:0]      r_victim;
  logic                  r_done;
  logic [7:0]            r_rdata;
  logic                  r_mem_req;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [LINE_W-1:0]     r_mem_wdata;
  logic [CNT_WIDTH-1:0]  r_hit_cnt;
  logic [CNT_WIDTH-1:0]  r_miss_cnt;

  logic                  r_valid [SETS][WAYS];
  logic                  r_dirty [SETS][WAYS];
  logic [WAY_W-1:0]      r_age   [SETS][WAYS];
  logic [TAG_W-1:0]      r_tag   [SETS][WAYS];
  logic [LINE_W-1:0]     r_data  [SETS][WAYS];

  logic [OFF_W-1:0]      w_off;
  logic [IDX_W-1:0]      w_idx;
  logic [TAG_W-1:0]      w_tag;
  logic                  w_hit;
  logic [WAY_W-1:0]      w_hit_way;
  logic                  w_inv_found;
  logic [WAY_W-1:0]      w_inv_way;
  logic [WAY_W-1:0]      w_lru_way;
  logic [WAY_W-1:0]      w_victim;
  logic                  w_vic_dirty;
  logic [WAY_W-1:0]      w_hit_age;
  logic [LINE_W-1:0]     w_hit_line;
  logic                  w_mem_done;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  assign w_off = r_addr[OFF_W-1:0];
  assign w_idx = r_addr[OFF_W +: IDX_W];
  assign w_tag = r_addr[ADDR_WIDTH-1 -: TAG_W];

  // Tag match, lowest invalid way and LRU way for the latched set
  always_comb begin
    w_hit       = 1'b0;
    w_hit_way   = '0;
    w_inv_found = 1'b0;
    w_inv_way   = '0;
    w_lru_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
      if (!r_valid[w_idx][w] && !w_inv_found) begin
        w_inv_found = 1'b1;
        w_inv_way   = WAY_W'(w);
      end
      if (r_age[w_idx][w] == WAY_W'(WAYS - 1)) begin
        w_lru_way = WAY_W'(w);
      end
    end
  end

  assign w_victim    = w_inv_found ? w_inv_way : w_lru_way;
  assign w_vic_dirty = r_valid[w_idx][w_victim] && r_dirty[w_idx][w_victim];
  assign w_hit_age   = r_age[w_idx][w_hit_way];
  assign w_hit_line  = r_data[w_idx][w_hit_way];
  assign w_mem_done  = r_mem_req && mem_ack;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (req) w_next = LOOKUP;
      LOOKUP:    if (w_hit)            w_next = IDLE;
                 else if (w_vic_dirty) w_next = WRITEBACK;
                 else                  w_next = REFILL;
      WRITEBACK: if (w_mem_done) w_next = REFILL;
      REFILL:    if (w_mem_done) w_next = LOOKUP;
      default:   w_next = IDLE;
    endcase
  end

  // Control state: handshake, line status, LRU ages and counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_first     <= 1'b0;
      r_done      <= 1'b0;
      r_rdata     <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_hit_cnt   <= '0;
      r_miss_cnt  <= '0;
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          r_valid[s][w] <= 1'b0;
          r_dirty[s][w] <= 1'b0;
          r_age[s][w]   <= WAY_W'(w);
        end
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (req) r_first <= 1'b1;
        LOOKUP: begin
          if (w_hit) begin
            r_done <= 1'b1;
            if (r_we) r_dirty[w_idx][w_hit_way] <= 1'b1;
            else      r_rdata <= w_hit_line[{w_off, 3'b000} +: 8];
            if (r_first) r_hit_cnt <= sat_inc(r_hit_cnt);
            for (int w = 0; w < WAYS; w++) begin
              if (r_age[w_idx][w] < w_hit_age) r_age[w_idx][w] <= r_age[w_idx][w] + WAY_W'(1);
            end
            r_age[w_idx][w_hit_way] <= '0;
          end else begin
            r_first    <= 1'b0;
            r_miss_cnt <= sat_inc(r_miss_cnt);
            r_mem_req  <= 1'b1;
            if (w_vic_dirty) begin
              r_mem_we    <= 1'b1;
              r_mem_addr  <= {r_tag[w_idx][w_victim], w_idx, {OFF_W{1'b0}}};
              r_mem_wdata <= r_data[w_idx][w_victim];
            end else begin
              r_mem_we   <= 1'b0;
              r_mem_addr <= {w_tag, w_idx, {OFF_W{1'b0}}};
            end
          end
        end
        WRITEBACK: if (w_mem_done) begin
          r_dirty[w_idx][r_victim] <= 1'b0;
          r_mem_req                <= 1'b0;
        end
        REFILL: begin
          // After a write-back the request drops for a cycle before the refill
          if (!r_mem_req) begin
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= {w_tag, w_idx, {OFF_W{1'b0}}};
          end else if (mem_ack) begin
            r_mem_req                <= 1'b0;
            r_valid[w_idx][r_victim] <= 1'b1;
            r_dirty[w_idx][r_victim] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Request latch, victim choice, tag and line storage
  always_ff @(posedge clk) begin
    if (r_state == IDLE && req) begin
      r_we    <= we;
      r_addr  <= address;
      r_wdata <= wdata;
    end
    if (r_state == LOOKUP && !w_hit) r_victim <= w_victim;
    if (r_state == LOOKUP && w_hit && r_we)
      r_data[w_idx][w_hit_way][{w_off, 3'b000} +: 8] <= r_wdata;
    if (r_state == REFILL && w_mem_done) begin
      r_data[w_idx][r_victim] <= mem_rdata;
      r_tag[w_idx][r_victim]  <= w_tag;
    end
  end

  assign ready      = (r_state == IDLE);
  assign done       = r_done;
  assign rdata      = r_rdata;
  assign mem_req    = r_mem_req;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign hit_count  = r_hit_cnt;
  assign miss_count = r_miss_cnt;

endmodule

// File: tb/tb_set_assoc_cache.sv
// Bench for set_assoc_cache: directed vector table, multi-cycle corner sequences
// and a randomized run against an MRU-ordered set model with a flat byte memory.
module tb_set_assoc_cache;
  localparam int SETS  = 128;
  localparam int WAYS  = 2;
  localparam int LIMIT = 100;

  logic        clk = 1'b0;
  logic        rst_n, req, we;
  logic [15:0] address;
  logic [7:0]  wdata;
  logic        ready, done;
  logic [7:0]  rdata;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_ack;
  logic [31:0] hit_count, miss_count;

  always #5 clk = ~clk;

  set_assoc_cache dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .address(address), .wdata(wdata),
    .ready(ready), .done(done), .rdata(rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] tb_mem  [0:65535];
  logic [7:0] ref_mem [0:65535];

  typedef struct { logic w; logic [15:0] a; logic [31:0] d; } mlog_t;
  mlog_t mlog[$];
  int resp_en, resp_delay, mreq_cycles, stab_viol;

  typedef struct {
    logic w; logic [15:0] a; logic [7:0] d;
    logic chk_rd; logic [7:0] rd;
    int n_mem; logic [15:0] wb_a; logic [31:0] wb_d; logic [15:0] rf_a;
    int hits; int misses;
  } vec_t;
  vec_t tv[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] line_of(input logic [7:0] m [0:65535], input int base);
    return {m[base+3], m[base+2], m[base+1], m[base]};
  endfunction

  // Backing memory: acks after resp_delay cycles (random when negative)
  initial begin
    int wait_left;
    int base;
    wait_left = -1;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (resp_en == 0 || mem_req !== 1'b1) begin
        wait_left = -1;
      end else begin
        if (wait_left < 0) wait_left = (resp_delay >= 0) ? resp_delay : int'($urandom_range(0, 4));
        if (wait_left == 0) begin
          base = int'(mem_addr) & ~3;
          if (mem_we) begin
            for (int k = 0; k < 4; k++) tb_mem[base+k] = mem_wdata[8*k +: 8];
            mlog.push_back('{1'b1, mem_addr, mem_wdata});
          end else begin
            mem_rdata = line_of(tb_mem, base);
            mlog.push_back('{1'b0, mem_addr, 32'h0});
          end
          mem_ack   = 1'b1;
          wait_left = -1;
        end else begin
          wait_left--;
        end
      end
    end
  end

  // Memory-port activity and stability while a request is held
  initial begin
    logic p_req, p_w;
    logic [15:0] p_a;
    logic [31:0] p_d;
    p_req = 1'b0; p_w = 1'b0; p_a = '0; p_d = '0;
    mreq_cycles = 0;
    stab_viol   = 0;
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1) begin
        mreq_cycles++;
        if (p_req && (mem_addr !== p_a || mem_we !== p_w || (mem_we && mem_wdata !== p_d)))
          stab_viol++;
      end
      p_req = (mem_req === 1'b1);
      p_a = mem_addr; p_w = mem_we; p_d = mem_wdata;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end

  task automatic access(input logic w, input logic [15:0] a, input logic [7:0] d,
                        output logic [7:0] rd, output int lat);
    req = 1'b1; we = w; address = a; wdata = d;
    @(posedge clk); #1;
    req = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < LIMIT) begin
      @(posedge clk); #1;
      lat++;
    end
    if (done !== 1'b1) begin
      n_vec++; n_err++;
      $display("FAIL timeout addr 0x%h: done=%b, want 1", a, done);
    end
    rd = rdata;
  endtask

  task automatic run_vec(input int i);
    logic [7:0] rd;
    int lat, m0;
    mlog.delete();
    m0 = mreq_cycles;
    access(tv[i].w, tv[i].a, tv[i].d, rd, lat);
    if (tv[i].chk_rd) chk($sformatf("v%0d rdata", i), 32'(rd), 32'(tv[i].rd));
    chk($sformatf("v%0d hit_latency", i), 32'(lat == 1), 32'(tv[i].n_mem == 0));
    chk($sformatf("v%0d hit_count", i), hit_count, 32'(tv[i].hits));
    chk($sformatf("v%0d miss_count", i), miss_count, 32'(tv[i].misses));
    chk($sformatf("v%0d mem_txns", i), 32'(mlog.size()), 32'(tv[i].n_mem));
    if (tv[i].n_mem == 0) chk($sformatf("v%0d mem_req_cycles", i), 32'(mreq_cycles - m0), 32'd0);
    if (tv[i].n_mem > 0 && mlog.size() == tv[i].n_mem) begin
      chk($sformatf("v%0d refill_we", i), 32'(mlog[mlog.size()-1].w), 32'd0);
      chk($sformatf("v%0d refill_addr", i), 32'(mlog[mlog.size()-1].a), 32'(tv[i].rf_a));
      if (tv[i].n_mem == 2) begin
        chk($sformatf("v%0d wb_addr", i), 32'(mlog[0].a), 32'(tv[i].wb_a));
        chk($sformatf("v%0d wb_data", i), mlog[0].d, tv[i].wb_d);
      end
    end
  endtask

  // Reference model: per set, resident tags ordered most- to least-recently used
  int set_tags [SETS][WAYS];
  bit set_dirty[SETS][WAYS];
  int set_cnt  [SETS];

  initial begin
    logic [7:0] rd;
    logic [15:0] a, wb_a, rf_a;
    logic [31:0] wb_d;
    logic [7:0] d, exp_rd;
    logic w;
    int lat, k, s, tag, pos, e_hits, e_miss, n_mem;
    bit e_hit, e_wb, dd;

    for (int i = 0; i < 65536; i++) tb_mem[i] = 8'(i * 7 + 3);
    {tb_mem[16'h0013], tb_mem[16'h0012], tb_mem[16'h0011], tb_mem[16'h0010]} = 32'h44332211;
    {tb_mem[16'h0213], tb_mem[16'h0212], tb_mem[16'h0211], tb_mem[16'h0210]} = 32'h88776655;
    {tb_mem[16'h0413], tb_mem[16'h0412], tb_mem[16'h0411], tb_mem[16'h0410]} = 32'h99AABBCC;
    {tb_mem[16'h0023], tb_mem[16'h0022], tb_mem[16'h0021], tb_mem[16'h0020]} = 32'h00000000;
    {tb_mem[16'h0223], tb_mem[16'h0222], tb_mem[16'h0221], tb_mem[16'h0220]} = 32'hDEADBEEF;
    {tb_mem[16'h0423], tb_mem[16'h0422], tb_mem[16'h0421], tb_mem[16'h0420]} = 32'h0BADF00D;

    //          w     addr      wdata  chk   rd    nm wb_a      wb_d          rf_a      h  m
    tv[0]  = '{1'b0, 16'h0010, 8'h00, 1'b1, 8'h11, 1, 16'h0000, 32'h00000000, 16'h0010, 0, 1};
    tv[1]  = '{1'b0, 16'h0013, 8'h00, 1'b1, 8'h44, 0, 16'h0000, 32'h00000000, 16'h0000, 1, 1};
    tv[2]  = '{1'b1, 16'h0011, 8'hAB, 1'b0, 8'h00, 0, 16'h0000, 32'h00000000, 16'h0000, 2, 1};
    tv[3]  = '{1'b0, 16'h0011, 8'h00, 1'b1, 8'hAB, 0, 16'h0000, 32'h00000000, 16'h0000, 3, 1};
    tv[4]  = '{1'b0, 16'h0210, 8'h00, 1'b1, 8'h55, 1, 16'h0000, 32'h00000000, 16'h0210, 3, 2};
    tv[5]  = '{1'b0, 16'h0210, 8'h00, 1'b1, 8'h55, 0, 16'h0000, 32'h00000000, 16'h0000, 4, 2};
    tv[6]  = '{1'b0, 16'h0410, 8'h00, 1'b1, 8'hCC, 2, 16'h0010, 32'h4433AB11, 16'h0410, 4, 3};
    tv[7]  = '{1'b0, 16'h0210, 8'h00, 1'b1, 8'h55, 0, 16'h0000, 32'h00000000, 16'h0000, 5, 3};
    tv[8]  = '{1'b1, 16'h0020, 8'h5A, 1'b0, 8'h00, 1, 16'h0000, 32'h00000000, 16'h0020, 0, 2};
    tv[9]  = '{1'b0, 16'h0220, 8'h00, 1'b1, 8'hEF, 1, 16'h0000, 32'h00000000, 16'h0220, 0, 3};
    tv[10] = '{1'b0, 16'h0420, 8'h00, 1'b1, 8'h0D, 2, 16'h0020, 32'h0000005A, 16'h0420, 0, 4};

    rst_n = 1'b0; req = 1'b0; we = 1'b0; address = '0; wdata = '0;
    resp_en = 1; resp_delay = 2;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset ready", 32'(ready), 32'd1);
    chk("reset done", 32'(done), 32'd0);
    chk("reset rdata", 32'(rdata), 32'd0);
    chk("reset mem_req", 32'(mem_req), 32'd0);
    chk("reset mem_we", 32'(mem_we), 32'd0);
    chk("reset mem_addr", 32'(mem_addr), 32'd0);
    chk("reset mem_wdata", mem_wdata, 32'd0);
    chk("reset hit_count", hit_count, 32'd0);
    chk("reset miss_count", miss_count, 32'd0);

    for (int i = 0; i <= 7; i++) run_vec(i);

    // Refill held for 5 cycles; a request in that window must be dropped
    resp_en = 0;
    req = 1'b1; we = 1'b0; address = 16'h0030; wdata = '0;
    @(posedge clk); #1;
    req = 1'b0;
    k = 0;
    while (mem_req !== 1'b1 && k < 20) begin @(posedge clk); #1; k++; end
    chk("hold mem_req", 32'(mem_req), 32'd1);
    for (int i = 0; i < 5; i++) begin
      req = 1'b1; we = 1'b1; address = 16'h0040; wdata = 8'hEE;
      @(posedge clk); #1;
      chk($sformatf("hold%0d mem_req", i), 32'(mem_req), 32'd1);
      chk($sformatf("hold%0d mem_we", i), 32'(mem_we), 32'd0);
      chk($sformatf("hold%0d mem_addr", i), 32'(mem_addr), 32'h0030);
      chk($sformatf("hold%0d ready", i), 32'(ready), 32'd0);
      chk($sformatf("hold%0d done", i), 32'(done), 32'd0);
    end
    req = 1'b0;
    resp_delay = 0;
    resp_en = 1;
    k = 0;
    while (done !== 1'b1 && k < LIMIT) begin @(posedge clk); #1; k++; end
    chk("hold done", 32'(done), 32'd1);
    chk("hold rdata", 32'(rdata), 32'(tb_mem[16'h0030]));
    chk("hold miss_count", miss_count, 32'd4);
    access(1'b0, 16'h0040, 8'h00, rd, lat);
    chk("ignored req misses", 32'(lat > 1), 32'd1);
    chk("ignored req rdata", 32'(rd), 32'(tb_mem[16'h0040]));
    chk("ignored req miss_count", miss_count, 32'd5);
    chk("hold stability", 32'(stab_viol), 32'd0);

    // Reset while a refill is outstanding
    resp_en = 0;
    req = 1'b1; we = 1'b0; address = 16'h0050;
    @(posedge clk); #1;
    req = 1'b0;
    k = 0;
    while (mem_req !== 1'b1 && k < 20) begin @(posedge clk); #1; k++; end
    chk("pre-reset mem_req", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midreset mem_req", 32'(mem_req), 32'd0);
    chk("midreset ready", 32'(ready), 32'd1);
    chk("midreset hit_count", hit_count, 32'd0);
    chk("midreset miss_count", miss_count, 32'd0);
    resp_en = 1; resp_delay = 1;
    access(1'b0, 16'h0010, 8'h00, rd, lat);
    chk("post-reset 0x0010 misses", 32'(lat > 1), 32'd1);
    chk("post-reset rdata", 32'(rd), 32'h11);
    chk("post-reset miss_count", miss_count, 32'd1);

    for (int i = 8; i <= 10; i++) run_vec(i);

    // Randomized run from a fresh reset
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    resp_delay = -1;
    ref_mem = tb_mem;
    for (int i = 0; i < SETS; i++) set_cnt[i] = 0;
    e_hits = 0; e_miss = 0;
    for (int n = 0; n < 300; n++) begin
      w = 1'($urandom_range(0, 1));
      a = 16'(($urandom_range(0, 3) << 9) | ($urandom_range(0, 2) << 2) | $urandom_range(0, 3));
      d = 8'($urandom);
      s = (int'(a) >> 2) % SETS;
      tag = int'(a) >> 9;
      pos = -1;
      for (int p = 0; p < set_cnt[s]; p++) if (set_tags[s][p] == tag) pos = p;
      e_hit = (pos >= 0);
      e_wb = 1'b0; wb_a = '0; wb_d = '0;
      rf_a = 16'((tag << 9) | (s << 2));
      if (e_hit) begin
        dd = set_dirty[s][pos];
        for (int p = pos; p > 0; p--) begin
          set_tags[s][p] = set_tags[s][p-1];
          set_dirty[s][p] = set_dirty[s][p-1];
        end
        e_hits++;
      end else begin
        if (set_cnt[s] == WAYS) begin
          if (set_dirty[s][WAYS-1]) begin
            e_wb = 1'b1;
            wb_a = 16'((set_tags[s][WAYS-1] << 9) | (s << 2));
            wb_d = line_of(ref_mem, int'(wb_a));
          end
          set_cnt[s]--;
        end
        for (int p = set_cnt[s]; p > 0; p--) begin
          set_tags[s][p] = set_tags[s][p-1];
          set_dirty[s][p] = set_dirty[s][p-1];
        end
        set_cnt[s]++;
        dd = 1'b0;
        e_miss++;
      end
      set_tags[s][0] = tag;
      set_dirty[s][0] = dd | w;
      exp_rd = ref_mem[a];
      if (w) ref_mem[a] = d;
      n_mem = e_hit ? 0 : (e_wb ? 2 : 1);

      mlog.delete();
      access(w, a, d, rd, lat);
      if (!w) chk($sformatf("r%0d rdata @%h", n, a), 32'(rd), 32'(exp_rd));
      chk($sformatf("r%0d hit @%h", n, a), 32'(lat == 1), 32'(e_hit));
      chk($sformatf("r%0d mem_txns", n), 32'(mlog.size()), 32'(n_mem));
      if (n_mem > 0 && mlog.size() == n_mem) begin
        chk($sformatf("r%0d refill_addr", n), 32'(mlog[mlog.size()-1].a), 32'(rf_a));
        if (e_wb) begin
          chk($sformatf("r%0d wb_addr", n), 32'(mlog[0].a), 32'(wb_a));
          chk($sformatf("r%0d wb_data", n), mlog[0].d, wb_d);
        end
      end
      chk($sformatf("r%0d hit_count", n), hit_count, 32'(e_hits));
      chk($sformatf("r%0d miss_count", n), miss_count, 32'(e_miss));
    end
    chk("random stability", 32'(stab_viol), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/set_assoc_cache.md
Name: set_assoc_cache

Overview:
- Parametrised N-way set-associative, write-back, write-allocate byte cache with true-LRU replacement.
- Sits between a core-side byte load/store port and a line-wide backing-memory port with a req/ack handshake.
- Generalises size, line length, associativity and address width.
- Adds dirty tracking, eviction write-back, miss refill and hit/miss counters.

Parameters:
- SIZE, 1024, total data capacity in bytes.
- LINE_BYTES, 4, bytes per line.
- WAYS, 2, associativity.
- ADDR_WIDTH, 16, byte-address width.
- CNT_WIDTH, 32, width of the performance counters.
- Derived: SETS = SIZE/(LINE_BYTES*WAYS); OFF_W = clog2(LINE_BYTES); IDX_W = clog2(SETS); TAG_W = ADDR_WIDTH-IDX_W-OFF_W.
- Constraints: all values are powers of two; TAG_W >= 1.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst_n  in  1  synchronous, active-low reset.
- req  in  1  core request; sampled only while ready=1.
- we  in  1  1 = write, 0 = read; qualified by req.
- address  in  ADDR_WIDTH  byte address.
- wdata  in  8  write byte.
- ready  out  1  cache idle and able to accept a request.
- done  out  1  one-cycle completion pulse, for reads and writes.
- rdata  out  8  read byte; valid when done=1 for a read.
- mem_req  out  1  backing-memory request.
- mem_we  out  1  1 = line write-back, 0 = line refill.
- mem_addr  out  ADDR_WIDTH  line-aligned address; low OFF_W bits are 0.
- mem_wdata  out  LINE_BYTES*8  write-back line; byte k sits at bits [8k+7:8k].
- mem_rdata  in  LINE_BYTES*8  refill line; same byte layout as mem_wdata.
- mem_ack  in  1  single-cycle completion of the current memory transaction.
- hit_count  out  CNT_WIDTH  saturating count of first-lookup hits.
- miss_count  out  CNT_WIDTH  saturating count of misses.

Behaviour:
- Address split: offset = address[OFF_W-1:0]; index = next IDX_W bits; tag = top TAG_W bits.
- Per line state: valid, dirty, tag, data. Per set: one age counter per way, clog2(WAYS) bits each.
- Reset (rst_n=0 at a clock edge):
  - Outputs: ready=1, done=0, rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, both counters 0.
  - Every valid and dirty bit cleared; the age of way w in every set is set to w.
  - Data and tag arrays are not cleared.
  - Reset mid-operation abandons any transaction. mem_req is 0 on the cycle after the reset edge. Dirty data is discarded.
- FSM states: IDLE, LOOKUP, WRITEBACK, REFILL.
  - ready = (state == IDLE).
- IDLE:
  - On req=1, latch we, address and wdata, then go to LOOKUP.
  - A req while ready=0 is ignored; nothing is queued.
- LOOKUP, hit on way h:
  - Read: rdata = the addressed byte. Write: store wdata into the byte and set dirty.
  - Assert done for one cycle, update LRU for h, return to IDLE.
  - Hit latency: done is high in the cycle after the accept edge, i.e. 2 clocks per request. ready is high in the same cycle as done.
- LOOKUP, miss:
  - Increment miss_count.
  - Victim = lowest-index invalid way; otherwise the way with age WAYS-1.
  - Victim valid and dirty: go to WRITEBACK. Otherwise go to REFILL.
- WRITEBACK:
  - Drive mem_req=1, mem_we=1, mem_addr={victim tag, index, 0}, mem_wdata = victim line.
  - Hold all of these stable until mem_ack.
  - On mem_ack clear the victim's dirty bit, deassert mem_req for one cycle, go to REFILL.
- REFILL:
  - Drive mem_req=1, mem_we=0, mem_addr={tag, index, 0}.
  - On mem_ack write mem_rdata into the victim way, set tag, valid=1, dirty=0, then go to LOOKUP.
  - The repeated LOOKUP hits and completes the request. This hit is not counted in hit_count.
- mem_ack while mem_req=0 is ignored. Memory ack latency is unbounded.
- LRU update on access to way h with previous age a:
  - Every way in the set with age < a increments.
  - Way h's age becomes 0.
  - Ages in a set always form a permutation of 0..WAYS-1.
- Counters saturate at all-ones and do not wrap.
- hit_count increments only on a hit in the first LOOKUP of a request.

Test Plan:
(Parameters at defaults: SETS=128, OFF_W=2, IDX_W=7, TAG_W=7.)
- Cold read 0x0010, memory acks with mem_rdata=0x44332211:
  - Expect mem_req=1, mem_we=0, mem_addr=0x0010; done with rdata=0x11; miss_count=1.
  - Then read 0x0013: done 1 cycle after accept, rdata=0x44, no mem_req, hit_count=1.
- Write 0x0011 with 0xAB (hit), then read 0x0011:
  - Expect rdata=0xAB and mem_req never asserted.
- LRU eviction, starting from the previous state:
  - Read 0x0210 (miss, fill with 0x88776655), read 0x0210 again, then read 0x0410.
  - Expect a write-back with mem_addr=0x0010 and mem_wdata=0x4433AB11, then a refill with mem_addr=0x0410.
  - A subsequent read of 0x0210 hits.
- Hold mem_ack low for 5 cycles during a refill:
  - mem_req, mem_addr and mem_we are stable; ready=0; done=0; a req in that window is ignored.
- Assert rst_n=0 for one cycle mid-REFILL:
  - The next cycle shows mem_req=0, ready=1, counters 0.
  - A read of 0x0010 then misses.
- Write miss to 0x0020 with 0x5A (refill 0x00000000), then evict it with 0x0220 and 0x0420:
  - Write-back carries mem_wdata=0x0000005A.
